// File: rtl/xpoint_if.sv
// Handshake bundle for one crosspoint controller: two input ports
// (horizontal, vertical), two registered output ports and the routing mode.
interface xpoint_if #(
    parameter int FLIT_SIZE = 64
);
    logic                 h_in_valid;
    logic [FLIT_SIZE-1:0] h_in_flit;
    logic                 h_in_ready;
    logic                 v_in_valid;
    logic [FLIT_SIZE-1:0] v_in_flit;
    logic                 v_in_ready;
    logic                 h_out_valid;
    logic [FLIT_SIZE-1:0] h_out_flit;
    logic                 h_out_ready;
    logic                 v_out_valid;
    logic [FLIT_SIZE-1:0] v_out_flit;
    logic                 v_out_ready;
    logic                 cross_enable;

    // Upstream/downstream side: drives input flits and output ready.
    modport master (
        output h_in_valid, h_in_flit, v_in_valid, v_in_flit,
        output h_out_ready, v_out_ready,
        input  h_in_ready, v_in_ready,
        input  h_out_valid, h_out_flit, v_out_valid, v_out_flit,
        input  cross_enable
    );

    // Crosspoint controller side.
    modport slave (
        input  h_in_valid, h_in_flit, v_in_valid, v_in_flit,
        input  h_out_ready, v_out_ready,
        output h_in_ready, v_in_ready,
        output h_out_valid, h_out_flit, v_out_valid, v_out_flit,
        output cross_enable
    );
endinterface

// File: rtl/xpoint_ctrl.sv
// Registered crosspoint controller: decodes head flits, arbitrates the
// routing mode between the horizontal and vertical inputs, holds the mode
// for a whole packet, and feeds one output register per direction.
module xpoint_ctrl #(
    parameter int FLIT_SIZE = 64,
    parameter int TURN_BIT  = FLIT_SIZE - 3
) (
    input  logic    clk,
    input  logic    rst_n,
    xpoint_if.slave bus
);

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    // Mode (0 = straight, 1 = crossed), round-robin pointer and packet locks.
    logic mode_q, mode_d;
    logic rr_q, rr_d;
    logic h_lock_q, h_lock_d;
    logic v_lock_q, v_lock_d;

    // Output registers.
    logic                 h_out_valid_q, h_out_valid_d;
    logic                 v_out_valid_q, v_out_valid_d;
    logic [FLIT_SIZE-1:0] h_out_flit_q, h_out_flit_d;
    logic [FLIT_SIZE-1:0] v_out_flit_q, v_out_flit_d;

    // Decode and arbitration terms.
    flit_type_e h_type, v_type;
    logic h_is_head, v_is_head, h_head_pend, v_head_pend;
    logic h_desire, v_desire;
    logic any_lock, cand_is_h, cand_valid, cand_desire, do_switch;
    logic h_out_free, v_out_free, h_tgt_free, v_tgt_free;
    logic h_elig, v_elig, h_ready, v_ready, h_acc, v_acc;
    logic h_load, v_load;

    // Decode input flits, pick the switch candidate and compute acceptance.
    always_comb begin
        h_type      = flit_type_e'(bus.h_in_flit[FLIT_SIZE-1 -: 2]);
        v_type      = flit_type_e'(bus.v_in_flit[FLIT_SIZE-1 -: 2]);
        h_is_head   = (h_type == FT_HEAD) || (h_type == FT_SINGLE);
        v_is_head   = (v_type == FT_HEAD) || (v_type == FT_SINGLE);
        h_head_pend = bus.h_in_valid && h_is_head;
        v_head_pend = bus.v_in_valid && v_is_head;
        h_desire    = bus.h_in_flit[TURN_BIT];
        v_desire    = bus.v_in_flit[TURN_BIT];

        // The mode may only move between packets; the favoured input's head
        // is considered first, the other input's head otherwise.
        any_lock    = h_lock_q || v_lock_q;
        cand_is_h   = rr_q ? !v_head_pend : h_head_pend;
        cand_valid  = h_head_pend || v_head_pend;
        cand_desire = cand_is_h ? h_desire : v_desire;
        do_switch   = !any_lock && cand_valid && (cand_desire != mode_q);

        // Target register may be loaded if empty or draining this cycle.
        h_out_free = !h_out_valid_q || bus.h_out_ready;
        v_out_free = !v_out_valid_q || bus.v_out_ready;
        h_tgt_free = mode_q ? v_out_free : h_out_free;
        v_tgt_free = mode_q ? h_out_free : v_out_free;

        // Locked inputs and unlocked body/tail flits pass; heads need a
        // matching mode.
        h_elig = h_lock_q || !h_is_head || (h_desire == mode_q);
        v_elig = v_lock_q || !v_is_head || (v_desire == mode_q);

        h_ready = rst_n && h_tgt_free && !do_switch && h_elig;
        v_ready = rst_n && v_tgt_free && !do_switch && v_elig;
        h_acc   = bus.h_in_valid && h_ready;
        v_acc   = bus.v_in_valid && v_ready;
    end

    // Next-state for mode, round-robin, locks and output registers.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        mode_d        = mode_q;
        rr_d          = rr_q;
        h_lock_d      = h_lock_q;
        v_lock_d      = v_lock_q;
        h_out_valid_d = h_out_valid_q && !bus.h_out_ready;
        v_out_valid_d = v_out_valid_q && !bus.v_out_ready;
        h_out_flit_d  = h_out_flit_q;
        v_out_flit_d  = v_out_flit_q;

        if (do_switch) begin
            mode_d = ~mode_q;
        end

        if (!rr_q && h_acc && h_is_head) begin
            rr_d = 1'b1;
        end else if (rr_q && v_acc && v_is_head) begin
            rr_d = 1'b0;
        end

        if (h_acc && h_type == FT_HEAD) h_lock_d = 1'b1;
        if (h_acc && h_type == FT_TAIL) h_lock_d = 1'b0;
        if (v_acc && v_type == FT_HEAD) v_lock_d = 1'b1;
        if (v_acc && v_type == FT_TAIL) v_lock_d = 1'b0;

        // A load wins over a drain in the same cycle.
        h_load = mode_q ? v_acc : h_acc;
        v_load = mode_q ? h_acc : v_acc;
        if (h_load) begin
            h_out_valid_d = 1'b1;
            h_out_flit_d  = mode_q ? bus.v_in_flit : bus.h_in_flit;
        end
        if (v_load) begin
            v_out_valid_d = 1'b1;
            v_out_flit_d  = mode_q ? bus.h_in_flit : bus.v_in_flit;
        end
    end

    // State registers; reset drops in-flight flits and any open packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= 1'b0;
            rr_q          <= 1'b0;
            h_lock_q      <= 1'b0;
            v_lock_q      <= 1'b0;
            h_out_valid_q <= 1'b0;
            v_out_valid_q <= 1'b0;
            // NOTE: the flit registers are cleared too because their
            // value is visible on the ports straight out of reset.
            h_out_flit_q  <= '0;
            v_out_flit_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // the pre-edge values regardless of statement order.
            mode_q        <= mode_d;
            rr_q          <= rr_d;
            h_lock_q      <= h_lock_d;
            v_lock_q      <= v_lock_d;
            h_out_valid_q <= h_out_valid_d;
            v_out_valid_q <= v_out_valid_d;
            h_out_flit_q  <= h_out_flit_d;
            v_out_flit_q  <= v_out_flit_d;
        end
    end

    assign bus.h_in_ready   = h_ready;
    assign bus.v_in_ready   = v_ready;
    assign bus.h_out_valid  = h_out_valid_q;
    assign bus.v_out_valid  = v_out_valid_q;
    assign bus.h_out_flit   = h_out_flit_q;
    assign bus.v_out_flit   = v_out_flit_q;
    assign bus.cross_enable = mode_q;

endmodule

// File: tb/tb_xpoint_ctrl.sv
// Directed bench for xpoint_ctrl: one task per scenario, inline comparisons
// against hand-computed values.
module tb_xpoint_ctrl;
    localparam int FS = 64;

    localparam logic [FS-1:0] S_H_T0  = 64'hC000_0000_0000_00AA; // single, turn 0
    localparam logic [FS-1:0] S_T1_A  = 64'hE000_0000_0000_00BB; // single, turn 1
    localparam logic [FS-1:0] S_T1_B  = 64'hE000_0000_0000_00BC; // single, turn 1
    localparam logic [FS-1:0] S_V_A   = 64'hC000_0000_0000_00CC; // single, turn 0
    localparam logic [FS-1:0] S_V_B   = 64'hC000_0000_0000_00CD; // single, turn 0
    localparam logic [FS-1:0] H_T1    = 64'h6000_0000_0000_0001; // head, turn 1
    localparam logic [FS-1:0] B_1     = 64'h0000_0000_0000_0002; // body
    localparam logic [FS-1:0] T_1     = 64'h8000_0000_0000_0003; // tail
    localparam logic [FS-1:0] VH_T0   = 64'h4000_0000_0000_0010; // head, turn 0
    localparam logic [FS-1:0] VB_1    = 64'h0000_0000_0000_0011;
    localparam logic [FS-1:0] VB_2    = 64'h0000_0000_0000_0012;
    localparam logic [FS-1:0] VT_1    = 64'h8000_0000_0000_0013;
    localparam logic [FS-1:0] HH_T0   = 64'h4000_0000_0000_0020; // head, turn 0

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    xpoint_if #(.FLIT_SIZE(FS)) bus ();

    xpoint_ctrl #(.FLIT_SIZE(FS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.h_in_valid = 1'b0;
        bus.v_in_valid = 1'b0;
        bus.h_in_flit  = '0;
        bus.v_in_flit  = '0;
    endtask

    task automatic do_reset();
        idle();
        bus.h_out_ready = 1'b1;
        bus.v_out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.h_out_ready = 1'b1;
        bus.v_out_ready = 1'b1;
        bus.h_in_valid = 1'b1;
        bus.h_in_flit  = S_H_T0;
        bus.v_in_valid = 1'b1;
        bus.v_in_flit  = S_V_A;
        repeat (2) @(posedge clk);
        #1;
        if (bus.h_in_ready !== 1'b0) begin $display("FAIL rst_h_in_ready got=%0b exp=0", bus.h_in_ready); errors++; end checks++;
        if (bus.v_in_ready !== 1'b0) begin $display("FAIL rst_v_in_ready got=%0b exp=0", bus.v_in_ready); errors++; end checks++;
        if (bus.h_out_valid !== 1'b0) begin $display("FAIL rst_h_out_valid got=%0b exp=0", bus.h_out_valid); errors++; end checks++;
        if (bus.v_out_valid !== 1'b0) begin $display("FAIL rst_v_out_valid got=%0b exp=0", bus.v_out_valid); errors++; end checks++;
        if (bus.h_out_flit !== '0) begin $display("FAIL rst_h_out_flit got=%h exp=0", bus.h_out_flit); errors++; end checks++;
        if (bus.v_out_flit !== '0) begin $display("FAIL rst_v_out_flit got=%h exp=0", bus.v_out_flit); errors++; end checks++;
        if (bus.cross_enable !== 1'b0) begin $display("FAIL rst_cross got=%0b exp=0", bus.cross_enable); errors++; end checks++;
        idle();
    endtask

    task automatic test_straight_single();
        do_reset();
        bus.h_in_valid = 1'b1;
        bus.h_in_flit  = S_H_T0;
        #1;
        if (bus.h_in_ready !== 1'b1) begin $display("FAIL t1_h_in_ready got=%0b exp=1", bus.h_in_ready); errors++; end checks++;
        if (bus.cross_enable !== 1'b0) begin $display("FAIL t1_cross_c0 got=%0b exp=0", bus.cross_enable); errors++; end checks++;
        tick();
        idle();
        if (bus.h_out_valid !== 1'b1) begin $display("FAIL t1_h_out_valid got=%0b exp=1", bus.h_out_valid); errors++; end checks++;
        if (bus.h_out_flit !== S_H_T0) begin $display("FAIL t1_h_out_flit got=%h exp=%h", bus.h_out_flit, S_H_T0); errors++; end checks++;
        if (bus.v_out_valid !== 1'b0) begin $display("FAIL t1_v_out_valid got=%0b exp=0", bus.v_out_valid); errors++; end checks++;
        if (bus.cross_enable !== 1'b0) begin $display("FAIL t1_cross_c1 got=%0b exp=0", bus.cross_enable); errors++; end checks++;
        tick();
        if (bus.h_out_valid !== 1'b0) begin $display("FAIL t1_drained got=%0b exp=0", bus.h_out_valid); errors++; end checks++;
    endtask

    task automatic test_turn();
        do_reset();
        bus.h_in_valid = 1'b1;
        bus.h_in_flit  = H_T1;
        #1;
        if (bus.h_in_ready !== 1'b0) begin $display("FAIL t2_bubble_ready got=%0b exp=0", bus.h_in_ready); errors++; end checks++;
        tick();
        if (bus.cross_enable !== 1'b1) begin $display("FAIL t2_cross_c1 got=%0b exp=1", bus.cross_enable); errors++; end checks++;
        if (bus.h_in_ready !== 1'b1) begin $display("FAIL t2_head_ready got=%0b exp=1", bus.h_in_ready); errors++; end checks++;
        tick();
        if (bus.v_out_valid !== 1'b1 || bus.v_out_flit !== H_T1) begin $display("FAIL t2_vout_head got=%0b/%h exp=1/%h", bus.v_out_valid, bus.v_out_flit, H_T1); errors++; end checks++;
        if (bus.h_out_valid !== 1'b0) begin $display("FAIL t2_h_out_valid got=%0b exp=0", bus.h_out_valid); errors++; end checks++;
        bus.h_in_flit = B_1;
        #1;
        if (bus.h_in_ready !== 1'b1) begin $display("FAIL t2_body_ready got=%0b exp=1", bus.h_in_ready); errors++; end checks++;
        tick();
        if (bus.v_out_flit !== B_1) begin $display("FAIL t2_vout_body got=%h exp=%h", bus.v_out_flit, B_1); errors++; end checks++;
        bus.h_in_flit = T_1;
        #1;
        if (bus.h_in_ready !== 1'b1) begin $display("FAIL t2_tail_ready got=%0b exp=1", bus.h_in_ready); errors++; end checks++;
        tick();
        idle();
        if (bus.v_out_flit !== T_1) begin $display("FAIL t2_vout_tail got=%h exp=%h", bus.v_out_flit, T_1); errors++; end checks++;
        if (bus.cross_enable !== 1'b1) begin $display("FAIL t2_cross_end got=%0b exp=1", bus.cross_enable); errors++; end checks++;
    endtask

    task automatic test_lock_hold();
        do_reset();
        bus.v_in_valid = 1'b1;
        bus.v_in_flit  = VH_T0;
        #1;
        if (bus.v_in_ready !== 1'b1) begin $display("FAIL t3_vhead_ready got=%0b exp=1", bus.v_in_ready); errors++; end checks++;
        tick();
        bus.v_in_flit  = VB_1;
        bus.h_in_valid = 1'b1;
        bus.h_in_flit  = H_T1;
        #1;
        if (bus.h_in_ready !== 1'b0) begin $display("FAIL t3_hstall_c1 got=%0b exp=0", bus.h_in_ready); errors++; end checks++;
        if (bus.v_in_ready !== 1'b1) begin $display("FAIL t3_vbody_ready got=%0b exp=1", bus.v_in_ready); errors++; end checks++;
        tick();
        bus.v_in_flit = VB_2;
        #1;
        if (bus.h_in_ready !== 1'b0) begin $display("FAIL t3_hstall_c2 got=%0b exp=0", bus.h_in_ready); errors++; end checks++;
        tick();
        bus.v_in_flit = VT_1;
        #1;
        if (bus.v_in_ready !== 1'b1 || bus.h_in_ready !== 1'b0) begin $display("FAIL t3_tail_cycle got=v%0b/h%0b exp=v1/h0", bus.v_in_ready, bus.h_in_ready); errors++; end checks++;
        if (bus.cross_enable !== 1'b0) begin $display("FAIL t3_cross_tail got=%0b exp=0", bus.cross_enable); errors++; end checks++;
        tick();
        bus.v_in_valid = 1'b0;
        if (bus.v_out_flit !== VT_1) begin $display("FAIL t3_vout_tail got=%h exp=%h", bus.v_out_flit, VT_1); errors++; end checks++;
        #1;
        if (bus.h_in_ready !== 1'b0) begin $display("FAIL t3_switch_bubble got=%0b exp=0", bus.h_in_ready); errors++; end checks++;
        tick();
        if (bus.cross_enable !== 1'b1) begin $display("FAIL t3_cross_rise got=%0b exp=1", bus.cross_enable); errors++; end checks++;
        if (bus.h_in_ready !== 1'b1) begin $display("FAIL t3_hhead_ready got=%0b exp=1", bus.h_in_ready); errors++; end checks++;
        tick();
        idle();
        if (bus.v_out_valid !== 1'b1 || bus.v_out_flit !== H_T1) begin $display("FAIL t3_vout_hhead got=%0b/%h exp=1/%h", bus.v_out_valid, bus.v_out_flit, H_T1); errors++; end checks++;
    endtask

    task automatic test_conflict();
        do_reset();
        bus.h_in_valid = 1'b1;
        bus.h_in_flit  = S_T1_A;
        bus.v_in_valid = 1'b1;
        bus.v_in_flit  = VH_T0;
        #1;
        if (bus.h_in_ready !== 1'b0 || bus.v_in_ready !== 1'b0) begin $display("FAIL t4_bubble got=h%0b/v%0b exp=h0/v0", bus.h_in_ready, bus.v_in_ready); errors++; end checks++;
        tick();
        if (bus.cross_enable !== 1'b1) begin $display("FAIL t4_cross_h got=%0b exp=1", bus.cross_enable); errors++; end checks++;
        if (bus.h_in_ready !== 1'b1 || bus.v_in_ready !== 1'b0) begin $display("FAIL t4_h_wins got=h%0b/v%0b exp=h1/v0", bus.h_in_ready, bus.v_in_ready); errors++; end checks++;
        tick();
        // h offers another turn-1 single: with rr now favouring v, v's head
        // drives a switch back and h must wait.
        bus.h_in_flit = S_T1_B;
        if (bus.v_out_valid !== 1'b1 || bus.v_out_flit !== S_T1_A) begin $display("FAIL t4_vout_h got=%0b/%h exp=1/%h", bus.v_out_valid, bus.v_out_flit, S_T1_A); errors++; end checks++;
        #1;
        if (bus.h_in_ready !== 1'b0 || bus.v_in_ready !== 1'b0) begin $display("FAIL t4_rr_switch got=h%0b/v%0b exp=h0/v0", bus.h_in_ready, bus.v_in_ready); errors++; end checks++;
        tick();
        if (bus.cross_enable !== 1'b0) begin $display("FAIL t4_cross_back got=%0b exp=0", bus.cross_enable); errors++; end checks++;
        if (bus.v_in_ready !== 1'b1 || bus.h_in_ready !== 1'b0) begin $display("FAIL t4_v_accept got=v%0b/h%0b exp=v1/h0", bus.v_in_ready, bus.h_in_ready); errors++; end checks++;
        tick();
        idle();
        if (bus.v_out_valid !== 1'b1 || bus.v_out_flit !== VH_T0) begin $display("FAIL t4_vout_v got=%0b/%h exp=1/%h", bus.v_out_valid, bus.v_out_flit, VH_T0); errors++; end checks++;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.v_out_ready = 1'b0;
        bus.v_in_valid  = 1'b1;
        bus.v_in_flit   = S_V_A;
        #1;
        if (bus.v_in_ready !== 1'b1) begin $display("FAIL t5_first_ready got=%0b exp=1", bus.v_in_ready); errors++; end checks++;
        tick();
        if (bus.v_out_valid !== 1'b1 || bus.v_out_flit !== S_V_A) begin $display("FAIL t5_vout_a got=%0b/%h exp=1/%h", bus.v_out_valid, bus.v_out_flit, S_V_A); errors++; end checks++;
        bus.v_in_flit = S_V_B;
        #1;
        if (bus.v_in_ready !== 1'b0) begin $display("FAIL t5_full_ready got=%0b exp=0", bus.v_in_ready); errors++; end checks++;
        tick();
        if (bus.v_out_valid !== 1'b1 || bus.v_out_flit !== S_V_A) begin $display("FAIL t5_hold got=%0b/%h exp=1/%h", bus.v_out_valid, bus.v_out_flit, S_V_A); errors++; end checks++;
        bus.v_out_ready = 1'b1;
        #1;
        if (bus.v_in_ready !== 1'b1) begin $display("FAIL t5_drain_ready got=%0b exp=1", bus.v_in_ready); errors++; end checks++;
        tick();
        idle();
        if (bus.v_out_valid !== 1'b1 || bus.v_out_flit !== S_V_B) begin $display("FAIL t5_load_drain got=%0b/%h exp=1/%h", bus.v_out_valid, bus.v_out_flit, S_V_B); errors++; end checks++;
        tick();
        if (bus.v_out_valid !== 1'b0) begin $display("FAIL t5_empty got=%0b exp=0", bus.v_out_valid); errors++; end checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.h_in_valid = 1'b1;
        bus.h_in_flit  = H_T1;
        tick();
        tick();
        bus.h_in_flit = B_1;
        if (bus.cross_enable !== 1'b1 || bus.v_out_valid !== 1'b1) begin $display("FAIL t6_pre got=c%0b/v%0b exp=c1/v1", bus.cross_enable, bus.v_out_valid); errors++; end checks++;
        #1;
        if (bus.h_in_ready !== 1'b1) begin $display("FAIL t6_body_ready got=%0b exp=1", bus.h_in_ready); errors++; end checks++;
        rst_n = 1'b0;
        #1;
        if (bus.h_out_valid !== 1'b0 || bus.v_out_valid !== 1'b0) begin $display("FAIL t6_valids got=h%0b/v%0b exp=0/0", bus.h_out_valid, bus.v_out_valid); errors++; end checks++;
        if (bus.h_out_flit !== '0 || bus.v_out_flit !== '0) begin $display("FAIL t6_flits got=%h/%h exp=0/0", bus.h_out_flit, bus.v_out_flit); errors++; end checks++;
        if (bus.cross_enable !== 1'b0) begin $display("FAIL t6_cross got=%0b exp=0", bus.cross_enable); errors++; end checks++;
        if (bus.h_in_ready !== 1'b0 || bus.v_in_ready !== 1'b0) begin $display("FAIL t6_readys got=h%0b/v%0b exp=0/0", bus.h_in_ready, bus.v_in_ready); errors++; end checks++;
        idle();
        tick();
        rst_n = 1'b1;
        bus.h_in_valid = 1'b1;
        bus.h_in_flit  = HH_T0;
        #1;
        if (bus.h_in_ready !== 1'b1) begin $display("FAIL t6_no_bubble got=%0b exp=1", bus.h_in_ready); errors++; end checks++;
        tick();
        idle();
        if (bus.h_out_valid !== 1'b1 || bus.h_out_flit !== HH_T0) begin $display("FAIL t6_hout got=%0b/%h exp=1/%h", bus.h_out_valid, bus.h_out_flit, HH_T0); errors++; end checks++;
        if (bus.cross_enable !== 1'b0) begin $display("FAIL t6_cross_after got=%0b exp=0", bus.cross_enable); errors++; end checks++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle();
        bus.h_out_ready = 1'b1;
        bus.v_out_ready = 1'b1;
        test_reset();
        test_straight_single();
        test_turn();
        test_lock_hold();
        test_conflict();
        test_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
